// File: rtl/mem_responder_multi.sv
// mem_responder_multi: wait-stated word RAM responder with byte/halfword lanes and load extension.
// Define MISALIGN_CHECK_EN to flag (and suppress) misaligned halfword/word accesses.
module mem_responder_multi #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oReadData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oMisaligned
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [AW+1:0] addr;
  logic [31:0] wdata, word, word_sh, ld, wr_rep;
  logic [2:0] f3;
  logic [1:0] size;
  logic [3:0] wmask;
  logic [7:0] b;
  logic [15:0] h;
  logic wr, mis, accept, unused_addr;
  logic [31:0] ram [DEPTH];

  // 0 = byte, 1 = halfword, 2 = word; unsigned byte/half codes only exist for loads
  function automatic logic [1:0] size_of(input logic [2:0] f, input logic w);
    return (f == 3'b000 || (!w && f == 3'b100)) ? 2'd0 :
           (f == 3'b001 || (!w && f == 3'b101)) ? 2'd1 : 2'd2;
  endfunction

  assign accept      = state == S_IDLE && (iMemRead || iMemWrite);
  assign size        = size_of(f3, wr);
  assign unused_addr = ^iAddress[31:AW+2];
  assign oReady      = state == S_DONE;
  assign oBusy       = state != S_IDLE;

  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) state <= S_IDLE;
    else state <= state_nx;

  always_comb
    state_nx = state == S_IDLE   ? (accept ? (WAIT_CYCLES != 0 ? S_WAIT : S_ACCESS) : S_IDLE) :
               state == S_WAIT   ? (cnt == 4'd1 ? S_ACCESS : S_WAIT) :
               state == S_ACCESS ? S_DONE : S_IDLE;

  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) cnt <= '0;
    else if (accept) cnt <= 4'(WAIT_CYCLES);
    else if (state == S_WAIT) cnt <= cnt - 4'd1;

  // write wins when both strobes are present
  always_ff @(posedge iCLK)
    if (accept) begin
      addr  <= iAddress[AW+1:0];
      wdata <= iWriteData;
      f3    <= iFunct3;
      wr    <= iMemWrite;
    end

`ifdef MISALIGN_CHECK_EN
  logic [1:0] size_in;
  assign size_in = size_of(iFunct3, iMemWrite);
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) mis <= 1'b0;
    else if (accept) mis <= size_in == 2'd1 ? iAddress[0] : (size_in == 2'd2 && |iAddress[1:0]);
  assign oMisaligned = mis && state == S_DONE;
`else
  assign mis         = 1'b0;
  assign oMisaligned = 1'b0;
`endif

  assign wmask   = size == 2'd0 ? 4'b0001 << addr[1:0] : size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wr_rep  = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign word    = ram[addr[AW+1:2]];
  assign word_sh = word >> {addr[1:0], 3'b000};
  assign b       = word_sh[7:0];
  assign h       = addr[1] ? word[31:16] : word[15:0];
  assign ld      = size == 2'd0 ? {{24{~f3[2] & b[7]}}, b} :
                   size == 2'd1 ? {{16{~f3[2] & h[15]}}, h} : word;

  always_ff @(posedge iCLK)
    if (state == S_ACCESS && wr && !mis)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) ram[addr[AW+1:2]][8*i +: 8] <= wr_rep[8*i +: 8];

  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) oReadData <= '0;
    else if (state == S_ACCESS && !wr) oReadData <= mis ? '0 : ld;
endmodule
